// File: rtl/v810_cache_pkg.sv
// rtl/v810_cache_pkg.sv - default widths, address field slicing and fill FSM states
// Shared by v810_cache_fill. Byte address layout: {tag, index, word, 2'b00}.
package v810_cache_pkg;

    localparam int DEF_INDEX_WIDTH = 7;
    localparam int DEF_WORD_WIDTH  = 1;
    localparam int DEF_TAG_WIDTH   = 22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_TAGWR = 2'd2,
        ST_ERR   = 2'd3
    } fill_state_t;

    function automatic logic [31:0] field_mask(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    endfunction

    function automatic logic [31:0] word_field(input logic [31:0] addr, input int word_width);
        return (addr >> 2) & field_mask(word_width);
    endfunction

    function automatic logic [31:0] index_field(input logic [31:0] addr, input int word_width,
                                                input int index_width);
        return (addr >> (2 + word_width)) & field_mask(index_width);
    endfunction

    function automatic logic [31:0] tag_field(input logic [31:0] addr, input int tag_width);
        return addr >> (32 - tag_width);
    endfunction

endpackage

// File: rtl/v810_cache_fill.sv
// rtl/v810_cache_fill.sv - cache line fill engine: bus burst read into data RAM, then tag update
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   miss_req, miss_addr     fill request (held until fill_done/fill_err) and missing byte address
//   fill_busy/done/err      busy level, single-cycle completion and error pulses
//   bus_req, bus_addr       word-aligned read request; bus_ack/bus_rdata/bus_err response
//   dram_wr_*               data RAM write port, address {index, word}
//   tag_wr_*                tag RAM write port, data {valid, tag}
//   fwd_valid, fwd_data     requested word forwarded to the pipeline as it arrives
// Option: define V810_CACHE_CRITICAL_WORD_FIRST_EN to start the burst at the missed word
// (wrapping); otherwise the burst starts at word 0.
module v810_cache_fill
    import v810_cache_pkg::*;
#(
    parameter int index_width = DEF_INDEX_WIDTH,
    parameter int word_width  = DEF_WORD_WIDTH,
    parameter int tag_width   = DEF_TAG_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               miss_req,
    input  logic [31:0]                        miss_addr,
    output logic                               fill_busy,
    output logic                               fill_done,
    output logic                               fill_err,
    output logic                               bus_req,
    output logic [31:0]                        bus_addr,
    input  logic                               bus_ack,
    input  logic [31:0]                        bus_rdata,
    input  logic                               bus_err,
    output logic                               dram_wr_en,
    output logic [index_width+word_width-1:0]  dram_wr_address,
    output logic [31:0]                        dram_wr_data,
    output logic                               tag_wr_en,
    output logic [index_width-1:0]             tag_wr_address,
    output logic [tag_width:0]                 tag_wr_data,
    output logic                               fwd_valid,
    output logic [31:0]                        fwd_data
);

    localparam logic [word_width-1:0] word_one = word_width'(1);

    fill_state_t            state_q;
    logic [tag_width-1:0]   tag_q;
    logic [index_width-1:0] index_q;
    logic [word_width-1:0]  word_q;
    logic [word_width-1:0]  counter_q;
    logic                   bus_req_q;
    logic                   fill_busy_q;
    logic                   fill_done_q;
    logic                   fill_err_q;
    logic                   tag_wr_en_q;
    logic                   tag_valid_q;

    logic [word_width-1:0]  req_word;
    logic [word_width-1:0]  first_word;
    logic [word_width-1:0]  start_word;
    logic [word_width-1:0]  counter_next;
    logic                   ack_ok;
    logic                   last_beat;

    assign req_word = word_width'(word_field(miss_addr, word_width));

`ifdef V810_CACHE_CRITICAL_WORD_FIRST_EN
    assign first_word = req_word;
    assign start_word = word_q;
`else
    assign first_word = '0;
    assign start_word = '0;
`endif

    assign counter_next = counter_q + word_one;
    // The burst is complete once the counter would wrap back onto the word it started at.
    assign last_beat    = (counter_next == start_word);
    // An ack flagged with bus_err carries no usable data and is never written.
    assign ack_ok       = (state_q == ST_FETCH) && bus_ack && !bus_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tag_q       <= '0;
            index_q     <= '0;
            word_q      <= '0;
            counter_q   <= '0;
            bus_req_q   <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
            fill_err_q  <= 1'b0;
            tag_wr_en_q <= 1'b0;
            tag_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_req) begin
                        tag_q       <= tag_width'(tag_field(miss_addr, tag_width));
                        index_q     <= index_width'(index_field(miss_addr, word_width, index_width));
                        word_q      <= req_word;
                        counter_q   <= first_word;
                        bus_req_q   <= 1'b1;
                        fill_busy_q <= 1'b1;
                        state_q     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bus_ack) begin
                        if (bus_err) begin
                            // Line is left invalid so any words already written stay unreachable.
                            bus_req_q   <= 1'b0;
                            tag_wr_en_q <= 1'b1;
                            tag_valid_q <= 1'b0;
                            fill_err_q  <= 1'b1;
                            state_q     <= ST_ERR;
                        end else begin
                            counter_q <= counter_next;
                            if (last_beat) begin
                                bus_req_q   <= 1'b0;
                                tag_wr_en_q <= 1'b1;
                                tag_valid_q <= 1'b1;
                                fill_done_q <= 1'b1;
                                state_q     <= ST_TAGWR;
                            end
                        end
                    end
                end
                ST_TAGWR, ST_ERR: begin
                    tag_wr_en_q <= 1'b0;
                    tag_valid_q <= 1'b0;
                    fill_done_q <= 1'b0;
                    fill_err_q  <= 1'b0;
                    fill_busy_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fill_busy       = fill_busy_q;
    assign fill_done       = fill_done_q;
    assign fill_err        = fill_err_q;
    assign bus_req         = bus_req_q;
    assign bus_addr        = {tag_q, index_q, counter_q, 2'b00};
    assign dram_wr_en      = ack_ok;
    assign dram_wr_address = {index_q, counter_q};
    // Data ports are gated so they read zero whenever no write is in progress, including in reset.
    assign dram_wr_data    = ack_ok ? bus_rdata : 32'h0;
    assign tag_wr_en       = tag_wr_en_q;
    assign tag_wr_address  = index_q;
    assign tag_wr_data     = {tag_valid_q, tag_q};
    assign fwd_valid       = ack_ok && (counter_q == word_q);
    assign fwd_data        = fwd_valid ? bus_rdata : 32'h0;

endmodule
